// File: rtl/prog_run_ctrl_pkg.sv
// Shared widths and run-state encoding for the program loader / run supervisor.
package prog_run_ctrl_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned PC_W    = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CYCLE_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StDone,
        StTimeout
    } run_state_t;

endpackage

// File: rtl/prog_run_ctrl_load_writer.sv
// Registers each accepted load word and turns it into a one-cycle instruction or
// data memory write strobe; data words addressed beyond the data memory are dropped.
module prog_run_ctrl_load_writer
    import prog_run_ctrl_pkg::*;
#(
    parameter int unsigned IW = INSTR_W,
    parameter int unsigned IA = PC_W,
    parameter int unsigned DW = DATA_W
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          i_valid,
    input  logic          i_ready,
    input  logic          i_is_data,
    input  logic [IA-1:0] i_addr,
    input  logic [IW-1:0] i_data,
    output logic          o_im_we,
    output logic [IA-1:0] o_im_addr,
    output logic [IW-1:0] o_im_wdata,
    output logic          o_dm_we,
    output logic [DW-1:0] o_dm_addr,
    output logic [DW-1:0] o_dm_wdata,
    output logic          o_addr_err
);

    if (IA <= DW || IW < DW) begin : g_bad_widths
        $error("load_writer: need IA > DW and IW >= DW");
    end

    logic          w_hs;
    logic          w_addr_ok;
    logic          r_im_we;
    logic [IA-1:0] r_im_addr;
    logic [IW-1:0] r_im_wdata;
    logic          r_dm_we;
    logic [DW-1:0] r_dm_addr;
    logic [DW-1:0] r_dm_wdata;
    logic          r_addr_err;

    assign w_hs      = i_valid && i_ready;
    assign w_addr_ok = (i_addr[IA-1:DW] == '0);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_im_we <= w_hs && !i_is_data;
            r_dm_we <= w_hs && i_is_data && w_addr_ok;
            if (w_hs && !i_is_data) begin
                r_im_addr  <= i_addr;
                r_im_wdata <= i_data;
            end
            if (w_hs && i_is_data && w_addr_ok) begin
                r_dm_addr  <= i_addr[DW-1:0];
                r_dm_wdata <= i_data[DW-1:0];
            end
            if (w_hs && i_is_data && !w_addr_ok) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_dm_we    = r_dm_we;
    assign o_dm_addr  = r_dm_addr;
    assign o_dm_wdata = r_dm_wdata;
    assign o_addr_err = r_addr_err;

endmodule

// File: rtl/prog_run_ctrl.sv
// Loads the program/data image, pulses the core's start, then counts run cycles
// until the core halts or the watchdog limit is reached.
module prog_run_ctrl
    import prog_run_ctrl_pkg::*;
#(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 16'hFFFF,
    parameter int unsigned IW           = INSTR_W,
    parameter int unsigned IA           = PC_W,
    parameter int unsigned DW           = DATA_W
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_is_data,
    input  logic               ld_last,
    input  logic [IA-1:0]      ld_addr,
    input  logic [IW-1:0]      ld_data,
    output logic               im_we,
    output logic [IA-1:0]      im_addr,
    output logic [IW-1:0]      im_wdata,
    output logic               dm_we,
    output logic [DW-1:0]      dm_addr,
    output logic [DW-1:0]      dm_wdata,
    output logic               dut_start,
    input  logic               dut_halt,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               addr_err,
    output logic [CYCLE_W-1:0] cycles
);

    if (MAX_CYCLES < 1 || MAX_CYCLES > 16'hFFFF) begin : g_bad_max
        $error("prog_run_ctrl: MAX_CYCLES must be in 1..16'hFFFF");
    end
    if (START_CYCLES < 1) begin : g_bad_start
        $error("prog_run_ctrl: START_CYCLES must be at least 1");
    end

    localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0]     START_LAST = SCW'(START_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] CYC_LIMIT  = CYCLE_W'(MAX_CYCLES - 1);

    run_state_t         r_state;
    logic [SCW-1:0]     r_start_cnt;
    logic [CYCLE_W-1:0] r_cycles;
    logic               r_dut_start;
    logic               r_done;
    logic               r_timeout;
    logic               w_ld_ready;
    logic               w_hs;

    assign w_ld_ready = (r_state == StIdle) || (r_state == StLoad);
    assign w_hs       = ld_valid && w_ld_ready;

    prog_run_ctrl_load_writer #(
        .IW (IW),
        .IA (IA),
        .DW (DW)
    ) u_load_writer (
        .CLK        (CLK),
        .reset      (reset),
        .i_valid    (ld_valid),
        .i_ready    (w_ld_ready),
        .i_is_data  (ld_is_data),
        .i_addr     (ld_addr),
        .i_data     (ld_data),
        .o_im_we    (im_we),
        .o_im_addr  (im_addr),
        .o_im_wdata (im_wdata),
        .o_dm_we    (dm_we),
        .o_dm_addr  (dm_addr),
        .o_dm_wdata (dm_wdata),
        .o_addr_err (addr_err)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= StIdle;
            r_start_cnt <= '0;
            r_cycles    <= '0;
            r_dut_start <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StLoad: begin
                    if (w_hs) begin
                        if (ld_last) begin
                            r_state     <= StStart;
                            r_dut_start <= 1'b1;
                            r_start_cnt <= '0;
                        end else begin
                            r_state <= StLoad;
                        end
                    end
                end
                // Halt is ignored here: the core may still show a stale halt.
                StStart: begin
                    if (r_start_cnt == START_LAST) begin
                        r_state     <= StRun;
                        r_dut_start <= 1'b0;
                    end else begin
                        r_start_cnt <= r_start_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (dut_halt) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_cycles <= r_cycles + 1'b1;
                        if (r_cycles == CYC_LIMIT) begin
                            r_state   <= StTimeout;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                StDone, StTimeout: begin
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ld_ready  = w_ld_ready;
    assign busy      = (r_state == StLoad) || (r_state == StStart) || (r_state == StRun);
    assign dut_start = r_dut_start;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Drives two controllers (default watchdog and a 20-cycle watchdog) with the same
// stimulus and compares every cycle against a transaction-level reference model.
module tb_prog_run_ctrl;

    localparam int TB_START = 2;

    logic       CLK = 1'b0;
    logic       reset;
    logic       ld_valid;
    logic       ld_is_data;
    logic       ld_last;
    logic [9:0] ld_addr;
    logic [8:0] ld_data;
    logic       dut_halt;

    logic [1:0] o_ready, o_im_we, o_dm_we, o_start, o_busy, o_done, o_tmo, o_err;
    logic [9:0]  o_im_addr  [2];
    logic [8:0]  o_im_wdata [2];
    logic [7:0]  o_dm_addr  [2];
    logic [7:0]  o_dm_wdata [2];
    logic [15:0] o_cycles   [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model, one slot per DUT instance.
    bit         m_last_seen [2];
    bit         m_loading   [2];
    bit         m_running   [2];
    bit         m_done      [2];
    bit         m_tmo       [2];
    bit         m_err       [2];
    bit         m_im_we     [2];
    bit         m_dm_we     [2];
    int         m_start_left[2];
    int         m_cnt       [2];
    logic [9:0] m_im_addr   [2];
    logic [8:0] m_im_data   [2];
    logic [7:0] m_dm_addr   [2];
    logic [7:0] m_dm_data   [2];

    always #5 CLK = ~CLK;

    prog_run_ctrl u_dut_a (
        .CLK        (CLK),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (o_ready[0]),
        .ld_is_data (ld_is_data),
        .ld_last    (ld_last),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .im_we      (o_im_we[0]),
        .im_addr    (o_im_addr[0]),
        .im_wdata   (o_im_wdata[0]),
        .dm_we      (o_dm_we[0]),
        .dm_addr    (o_dm_addr[0]),
        .dm_wdata   (o_dm_wdata[0]),
        .dut_start  (o_start[0]),
        .dut_halt   (dut_halt),
        .busy       (o_busy[0]),
        .done       (o_done[0]),
        .timeout    (o_tmo[0]),
        .addr_err   (o_err[0]),
        .cycles     (o_cycles[0])
    );

    prog_run_ctrl #(
        .MAX_CYCLES (20)
    ) u_dut_b (
        .CLK        (CLK),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (o_ready[1]),
        .ld_is_data (ld_is_data),
        .ld_last    (ld_last),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .im_we      (o_im_we[1]),
        .im_addr    (o_im_addr[1]),
        .im_wdata   (o_im_wdata[1]),
        .dm_we      (o_dm_we[1]),
        .dm_addr    (o_dm_addr[1]),
        .dm_wdata   (o_dm_wdata[1]),
        .dut_start  (o_start[1]),
        .dut_halt   (dut_halt),
        .busy       (o_busy[1]),
        .done       (o_done[1]),
        .timeout    (o_tmo[1]),
        .addr_err   (o_err[1]),
        .cycles     (o_cycles[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int max_of(input int i);
        return (i == 0) ? 65535 : 20;
    endfunction

    task automatic model_step(input int i);
        bit hs;
        if (reset) begin
            m_last_seen[i]  = 0;
            m_loading[i]    = 0;
            m_running[i]    = 0;
            m_done[i]       = 0;
            m_tmo[i]        = 0;
            m_err[i]        = 0;
            m_im_we[i]      = 0;
            m_dm_we[i]      = 0;
            m_start_left[i] = 0;
            m_cnt[i]        = 0;
        end else begin
            hs = ld_valid && !m_last_seen[i];
            m_im_we[i] = hs && !ld_is_data;
            m_dm_we[i] = hs && ld_is_data && (ld_addr < 10'd256);
            if (hs && ld_is_data && ld_addr >= 10'd256) m_err[i] = 1;
            if (m_im_we[i]) begin
                m_im_addr[i] = ld_addr;
                m_im_data[i] = ld_data;
            end
            if (m_dm_we[i]) begin
                m_dm_addr[i] = ld_addr[7:0];
                m_dm_data[i] = ld_data[7:0];
            end
            if (m_running[i]) begin
                if (dut_halt) begin
                    m_done[i]    = 1;
                    m_running[i] = 0;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == max_of(i)) begin
                        m_tmo[i]     = 1;
                        m_running[i] = 0;
                    end
                end
            end else if (m_start_left[i] > 0) begin
                m_start_left[i]--;
                if (m_start_left[i] == 0) m_running[i] = 1;
            end
            if (hs) m_loading[i] = 1;
            if (hs && ld_last) begin
                m_last_seen[i]  = 1;
                m_start_left[i] = TB_START;
            end
        end
    endtask

    task automatic compare(input int i);
        string p;
        p = (i == 0) ? "a" : "b";
        check_val({p, ".ld_ready"}, 32'(o_ready[i]), 32'(!m_last_seen[i]));
        check_val({p, ".busy"}, 32'(o_busy[i]),
                  32'(m_loading[i] && !m_done[i] && !m_tmo[i]));
        check_val({p, ".dut_start"}, 32'(o_start[i]), 32'(m_start_left[i] > 0));
        check_val({p, ".done"}, 32'(o_done[i]), 32'(m_done[i]));
        check_val({p, ".timeout"}, 32'(o_tmo[i]), 32'(m_tmo[i]));
        check_val({p, ".addr_err"}, 32'(o_err[i]), 32'(m_err[i]));
        check_val({p, ".cycles"}, 32'(o_cycles[i]), 32'(m_cnt[i]));
        check_val({p, ".im_we"}, 32'(o_im_we[i]), 32'(m_im_we[i]));
        check_val({p, ".dm_we"}, 32'(o_dm_we[i]), 32'(m_dm_we[i]));
        if (m_im_we[i]) begin
            check_val({p, ".im_addr"}, 32'(o_im_addr[i]), 32'(m_im_addr[i]));
            check_val({p, ".im_wdata"}, 32'(o_im_wdata[i]), 32'(m_im_data[i]));
        end
        if (m_dm_we[i]) begin
            check_val({p, ".dm_addr"}, 32'(o_dm_addr[i]), 32'(m_dm_addr[i]));
            check_val({p, ".dm_wdata"}, 32'(o_dm_wdata[i]), 32'(m_dm_data[i]));
        end
    endtask

    // Inputs are set just after a negedge; the model steps, the DUTs take the edge,
    // and outputs are compared on the following negedge.
    task automatic tick();
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) compare(i);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input bit is_data, input bit last, input logic [9:0] addr,
                        input logic [8:0] data);
        ld_valid   = 1'b1;
        ld_is_data = is_data;
        ld_last    = last;
        ld_addr    = addr;
        ld_data    = data;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_image();
        send(1'b0, 1'b0, 10'd0, 9'h1A0);
        send(1'b0, 1'b0, 10'd1, 9'h0F3);
        send(1'b0, 1'b1, 10'd2, 9'h1FF);
    endtask

    initial begin
        int         n;
        logic [9:0] a;
        bit         isd;

        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_is_data = 1'b0;
        ld_last    = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        dut_halt   = 1'b0;
        @(negedge CLK);
        do_reset();
        check_val("reset.cycles", 32'(o_cycles[0]), 32'd0);
        check_val("reset.ld_ready", 32'(o_ready[0]), 32'd1);

        // Data words (one in range, one dropped), then a 3-word instruction image.
        send(1'b1, 1'b0, 10'h005, 9'h1AB);
        check_val("t2.dm_addr", 32'(o_dm_addr[0]), 32'h05);
        check_val("t2.dm_wdata", 32'(o_dm_wdata[0]), 32'hAB);
        send(1'b1, 1'b0, 10'h105, 9'h055);
        check_val("t2.addr_err", 32'(o_err[0]), 32'd1);
        load_image();
        check_val("t1.start", 32'(o_start[0]), 32'd1);

        // Stale halt during START, then 37 run cycles, then halt.
        dut_halt = 1'b1;
        ticks(TB_START);
        dut_halt = 1'b0;
        ticks(37);
        dut_halt = 1'b1;
        ld_valid = 1'b1;
        ticks(3);
        ld_valid = 1'b0;
        check_val("t3.done", 32'(o_done[0]), 32'd1);
        check_val("t3.cycles", 32'(o_cycles[0]), 32'd37);
        check_val("t3.busy", 32'(o_busy[0]), 32'd0);
        check_val("t4.timeout", 32'(o_tmo[1]), 32'd1);
        check_val("t4.cycles", 32'(o_cycles[1]), 32'd20);
        check_val("t4.done", 32'(o_done[1]), 32'd0);

        // Halt on exactly the 20th run cycle: done wins over the watchdog.
        dut_halt = 1'b0;
        do_reset();
        send(1'b0, 1'b1, 10'h3FF, 9'h155);
        ticks(TB_START);
        ticks(19);
        dut_halt = 1'b1;
        tick();
        check_val("t5.done", 32'(o_done[1]), 32'd1);
        check_val("t5.timeout", 32'(o_tmo[1]), 32'd0);
        check_val("t5.cycles", 32'(o_cycles[1]), 32'd19);

        // Reset lands on the handshake edge of word 2.
        dut_halt = 1'b0;
        do_reset();
        send(1'b0, 1'b0, 10'd0, 9'h1A0);
        ld_valid = 1'b1;
        ld_addr  = 10'd1;
        ld_data  = 9'h0F3;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        ld_valid = 1'b0;
        check_val("t6.im_we", 32'(o_im_we[0]), 32'd0);
        check_val("t6.busy", 32'(o_busy[0]), 32'd0);
        tick();
        load_image();
        ticks(TB_START + 5);
        dut_halt = 1'b1;
        tick();
        check_val("t6.cycles", 32'(o_cycles[0]), 32'd5);
        dut_halt = 1'b0;

        // Random images, gaps, halts and occasional mid-run resets.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            for (int w = 0; w < n; w++) begin
                while ($urandom_range(0, 2) == 0) tick();
                isd = 1'($urandom_range(0, 1));
                a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 255));
                dut_halt = 1'($urandom_range(0, 1));
                send(isd, w == n - 1, a, 9'($urandom));
            end
            n = $urandom_range(3, 45);
            for (int k = 0; k < n; k++) begin
                dut_halt = ($urandom_range(0, 14) == 0);
                ld_valid = 1'($urandom_range(0, 1));
                reset    = ($urandom_range(0, 60) == 0);
                tick();
                reset = 1'b0;
            end
            ld_valid = 1'b0;
            dut_halt = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Sits directly upstream of the processor top level: loads the program and initial data, starts the core, then supervises the run.
- Accepts a valid/ready word stream and turns it into one-cycle write strobes for the instruction memory (9-bit words) and the data memory (8-bit bytes).
- After the last word it drives the core's `start` for a fixed number of cycles, then counts cycles until the core raises `halt` or a watchdog limit expires.
- Exposes `done`, `timeout` and the cycle count to the test harness.

Parameters:
- START_CYCLES, 2, number of consecutive cycles `dut_start` is held high (≥1).
- MAX_CYCLES, 16'hFFFF, watchdog limit on run cycles.
- IW, 9, instruction word width.
- IA, 10, instruction address width (matches the 10-bit PC).
- DW, 8, data memory word and address width.

Ports:
- CLK  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted when ld_valid && ld_ready.
- ld_is_data  in  1  1 = data memory word, 0 = instruction word.
- ld_last  in  1  marks the final word of the image.
- ld_addr  in  IA  target address.
- ld_data  in  IW  payload; data words use [DW-1:0].
- im_we  out  1  instruction memory write strobe.
- im_addr  out  IA  instruction memory write address.
- im_wdata  out  IW  instruction memory write data.
- dm_we  out  1  data memory write strobe.
- dm_addr  out  DW  data memory write address.
- dm_wdata  out  DW  data memory write data.
- dut_start  out  1  drives the core's `start` input.
- dut_halt  in  1  the core's `halt` output.
- busy  out  1  high in LOAD, START and RUN.
- done  out  1  sticky; core halted.
- timeout  out  1  sticky; watchdog expired.
- addr_err  out  1  sticky; a data word addressed at or above 2**DW was dropped.
- cycles  out  16  run cycle count.

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high. Reset clears all outputs and registers to 0 and enters IDLE, including from mid-load or mid-run.
  - Any write strobe scheduled for the next cycle is cancelled.
  - dut_start is 0 on the cycle after reset.
- States: IDLE, LOAD, START, RUN, DONE, TIMEOUT.
- ld_ready: high in IDLE and LOAD, and only when no `ld_last` word has been accepted. Low in all other states.
- IDLE:
  - The first accepted word moves the block to LOAD.
  - That word is written exactly like any other word.
- Writes (IDLE and LOAD):
  - Each handshake registers address and data.
  - The matching strobe (im_we or dm_we) is high for exactly one cycle, the cycle after the handshake.
  - Back-to-back handshakes give back-to-back strobes; one word per cycle is sustained.
  - im_we and dm_we are never high together.
- Data word address check:
  - dm_addr = ld_addr[DW-1:0] and dm_wdata = ld_data[DW-1:0].
  - If ld_addr[IA-1:DW] != 0, no strobe is issued and addr_err is set.
- ld_last:
  - When the handshake carries ld_last, the next state is START.
  - START is entered on the same edge that issues that word's strobe.
- START:
  - dut_start is high for exactly START_CYCLES cycles; cycles is held at 0.
  - dut_halt is ignored throughout START, because the core may show a stale halt during its own reset.
  - After the last START cycle the block enters RUN.
- RUN:
  - dut_start = 0.
  - Each cycle with dut_halt = 0 increments cycles.
  - dut_halt = 1 → DONE. cycles freezes and is not incremented on that cycle.
  - If cycles == MAX_CYCLES-1 and dut_halt = 0 → TIMEOUT, with cycles = MAX_CYCLES.
  - If halt and the watchdog limit occur on the same cycle, DONE wins.
- DONE / TIMEOUT:
  - Terminal states: busy = 0 and the sticky flag is held.
  - ld_ready = 0 and ld_valid is ignored.
  - Only reset leaves these states.
- Width rules:
  - cycles is 16-bit unsigned and never wraps; MAX_CYCLES ≤ 16'hFFFF is enforced by an elaboration assertion.
  - Instruction addresses use all IA bits, so no instruction word is ever dropped.
- Latency:
  - Handshake to strobe: 1 cycle.
  - Last-word handshake to the first dut_start = 1 cycle: 1 cycle.

Decomposition:
- Shared definitions package:
  - State enum `run_state_t` (IDLE, LOAD, START, RUN, DONE, TIMEOUT).
  - Width constants for instruction word, PC and data.
- Sub-module `load_writer`:
  - Contains the handshake register, address range check and one-cycle strobe generation.
  - The top holds the FSM, START counter and watchdog counter.

Test Plan:
1. Reset, then stream 3 instruction words (addr 0,1,2; data 9'h1A0, 9'h0F3, 9'h1FF) with ld_last on the third. Expect im_we high for 3 consecutive cycles with matching addr/data, then dut_start high for 2 cycles.
2. Send a data word (ld_is_data = 1, addr 10'h005, data 9'h1AB) → dm_we for one cycle, dm_addr = 8'h05, dm_wdata = 8'hAB. Then send a data word to addr 10'h105 → no strobe, addr_err = 1.
3. Hold dut_halt = 1 during START, then drop it. Raise halt after 37 RUN cycles → done = 1, cycles = 37, busy = 0, and ld_ready stays 0.
4. Use MAX_CYCLES = 20 with halt never asserted → timeout = 1, cycles = 20. Then assert halt → flags unchanged.
5. Use MAX_CYCLES = 20 and assert halt on exactly the 20th RUN cycle → done = 1, timeout = 0.
6. Assert reset mid-load, on the handshake cycle of word 2 → no strobe the next cycle, state IDLE, all flags 0. Reload the full image and check that a normal run follows.
